fifo_pack: RTL and testbench

- Narrow-to-wide FIFO: accepts 8-bit bytes on the write side and delivers 16-bit words on the read side.
- It is the upstream counterpart of the team's 16-bit-in / 8-bit-out FIFO.
- Use case: collects a byte stream (e.g. from a UART receiver) and presents complete halfwords to 16-bit consumers.
- Storage is a byte-addressed register array; control is byte-granular on write and word-granular on read.

---
 rtl/fifo_pack.sv | 64 ++++++
 tb/tb_fifo_pack.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fifo_pack.sv
// Narrow-to-wide FIFO: 8-bit bytes in, little-endian 16-bit words out (first-word-fall-through).
// Optional pad-flush of a trailing odd byte when FIFO_PACK_FLUSH_EN is defined.
module fifo_pack #(
    parameter int ADDR_WIDTH = 3
) (
    input  logic        clk,
    input  logic        reset,
`ifdef FIFO_PACK_FLUSH_EN
    input  logic        flush,
`endif
    input  logic        wr,
    input  logic        rd,
    input  logic [7:0]  w_data,
    output logic [15:0] r_data,
    output logic        full,
    output logic        empty,
    output logic        half
);
    localparam int PW    = ADDR_WIDTH + 2;
    localparam int BYTES = 1 << (ADDR_WIDTH + 1);
    localparam logic [PW-1:0] CAP = {1'b1, {(PW-1){1'b0}}};

    logic [7:0]    mem [BYTES];
    logic [PW-1:0] wp, rp, count;
    logic [PW-2:0] rd_lo, rd_hi;
    logic          do_wr, do_rd, do_pad;

    assign count = wp - rp;
    assign full  = (count == CAP);
    assign empty = (count < PW'(2));
    assign half  = count[0];

    // Both requests are gated by the pre-edge flags, so a same-cycle rd never unblocks a write.
    assign do_wr = wr && !full;
    assign do_rd = rd && !empty;
`ifdef FIFO_PACK_FLUSH_EN
    // Capacity is even, so full cannot coincide with half and the pad write never stalls.
    assign do_pad = flush && !wr && half;
`else
    assign do_pad = 1'b0;
`endif

    // rp is always even, so the word's high byte sits at the odd neighbour.
    assign rd_lo  = rp[PW-2:0];
    assign rd_hi  = {rp[PW-2:1], 1'b1};
    assign r_data = {mem[rd_hi], mem[rd_lo]};

    // NOTE: the byte array is reset too, because r_data is observable straight from storage
    // and must read 16'h0000 while the FIFO is held in reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp <= '0;
            rp <= '0;
            for (int i = 0; i < BYTES; i++) mem[i] <= 8'h00;
        end else begin
            // NOTE: non-blocking updates let every pointer and byte read its pre-edge value.
            if (do_wr || do_pad) begin
                mem[wp[PW-2:0]] <= do_wr ? w_data : 8'h00;
                wp              <= wp + PW'(1);
            end
            if (do_rd) rp <= rp + PW'(2);
        end
    end
endmodule

// File: tb/tb_fifo_pack.sv
// Scoreboarded bench for fifo_pack: stimulus pushes expected words, a negedge monitor pops and compares on reads.
module tb_fifo_pack;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr = 1'b0, rd = 1'b0, flush = 1'b0;
    logic [7:0]  w_data = 8'h00;
    logic [15:0] r_data;
    logic        full, empty, half;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mq[$];     // bytes held by the reference model
    logic [15:0] exp_q[$];  // complete words awaiting a read

    fifo_pack #(.ADDR_WIDTH(3)) dut (
        .clk(clk), .reset(reset),
`ifdef FIFO_PACK_FLUSH_EN
        .flush(flush),
`endif
        .wr(wr), .rd(rd), .w_data(w_data),
        .r_data(r_data), .full(full), .empty(empty), .half(half)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // A read is committed at the next rising edge whenever rd=1 and empty=0 mid-cycle.
    always @(negedge clk) begin
        if (reset && rd && !empty) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL read_unexpected: got %h expected none", r_data);
            end else begin
                check("read_word", r_data, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string tag);
        int sz = mq.size();
        check({tag, "_empty"}, {15'd0, empty}, {15'd0, sz < 2});
        check({tag, "_full"},  {15'd0, full},  {15'd0, sz == 16});
        check({tag, "_half"},  {15'd0, half},  {15'd0, sz[0]});
    endtask

    task automatic op(input logic w, input logic r, input logic [7:0] d, input logic f);
        int  sz   = mq.size();
        bit  do_w = w && (sz < 16);
        bit  do_r = r && (sz >= 2);
        bit  do_p = 1'b0;
`ifdef FIFO_PACK_FLUSH_EN
        do_p = f && !w && sz[0];
`endif
        wr = w; rd = r; w_data = d; flush = f;
        tick();
        wr = 1'b0; rd = 1'b0; flush = 1'b0;
        if (do_r) begin
            void'(mq.pop_front());
            void'(mq.pop_front());
        end
        if (do_w || do_p) begin
            mq.push_back(do_w ? d : 8'h00);
            if (mq.size() % 2 == 0) exp_q.push_back({mq[mq.size()-1], mq[mq.size()-2]});
        end
        check_flags("op");
    endtask

    task automatic drain();
        int n = 0;
        while (!empty && n < 20) begin
            op(1'b0, 1'b1, 8'h00, 1'b0);
            n++;
        end
        check("drain_empty", {15'd0, empty}, 16'd1);
    endtask

    initial begin
        logic [7:0] lo, hi;
        // Reset state
        #2;
        check("rst_rdata", r_data, 16'h0000);
        check("rst_empty", {15'd0, empty}, 16'd1);
        check("rst_full",  {15'd0, full},  16'd0);
        check("rst_half",  {15'd0, half},  16'd0);
        #10 reset = 1'b1;

        // Packing order
        op(1'b1, 1'b0, 8'h11, 1'b0);
        check("pack_half1", {15'd0, half}, 16'd1);
        check("pack_empty1", {15'd0, empty}, 16'd1);
        op(1'b1, 1'b0, 8'h22, 1'b0);
        check("pack_rdata", r_data, 16'h2211);
        check("pack_empty2", {15'd0, empty}, 16'd0);
        op(1'b0, 1'b1, 8'h00, 1'b0);
        check("pack_empty3", {15'd0, empty}, 16'd1);

        // Full boundary, ignored 17th write, ordered drain
        for (int i = 0; i < 16; i++) op(1'b1, 1'b0, 8'(i), 1'b0);
        check("full_set", {15'd0, full}, 16'd1);
        op(1'b1, 1'b0, 8'hFF, 1'b0);
        check("full_hold", {15'd0, full}, 16'd1);
        check("full_head", r_data, 16'h0100);
        for (int i = 0; i < 8; i++) begin
            lo = 8'(2 * i);
            hi = 8'(2 * i + 1);
            check("full_seq", r_data, {hi, lo});
            op(1'b0, 1'b1, 8'h00, 1'b0);
        end
        check("full_drained", {15'd0, empty}, 16'd1);

        // Simultaneous wr+rd with 3 bytes stored
        op(1'b1, 1'b0, 8'hA1, 1'b0);
        op(1'b1, 1'b0, 8'hA2, 1'b0);
        op(1'b1, 1'b0, 8'hA3, 1'b0);
        op(1'b1, 1'b1, 8'hA4, 1'b0);
        check("sim3_half",  {15'd0, half},  16'd0);
        check("sim3_empty", {15'd0, empty}, 16'd0);
        check("sim3_rdata", r_data, 16'hA4A3);
        drain();

        // Simultaneous wr+rd when full: only the read happens
        for (int i = 0; i < 16; i++) op(1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
        op(1'b1, 1'b1, 8'hEE, 1'b0);
        check("simf_full", {15'd0, full}, 16'd0);
        check("simf_count", 16'(mq.size()), 16'd14);
        check("simf_head", r_data, 16'h8382);
        drain();

        // Wrap-around with occupancy kept small
        for (int i = 0; i < 40; i++) op(1'b1, mq.size() >= 4, 8'(8'h40 + i), 1'b0);
        drain();

        // Reset mid-stream
        op(1'b1, 1'b0, 8'h5A, 1'b0);
        op(1'b1, 1'b0, 8'h5B, 1'b0);
        op(1'b1, 1'b0, 8'h5C, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("mrst_rdata", r_data, 16'h0000);
        check("mrst_empty", {15'd0, empty}, 16'd1);
        check("mrst_full",  {15'd0, full},  16'd0);
        check("mrst_half",  {15'd0, half},  16'd0);
        mq.delete();
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;

`ifdef FIFO_PACK_FLUSH_EN
        op(1'b1, 1'b0, 8'hAB, 1'b0);
        op(1'b0, 1'b0, 8'h00, 1'b1);
        check("flush_rdata", r_data, 16'h00AB);
        check("flush_empty", {15'd0, empty}, 16'd0);
        check("flush_half",  {15'd0, half},  16'd0);
        op(1'b0, 1'b0, 8'h00, 1'b1);
        check("flush_noop", 16'(mq.size()), 16'd2);
        drain();
`endif

        check("scoreboard_left", 16'(exp_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
